// File: rtl/mdu_pkg.sv
// Shared opcodes and issue-state encoding for the ALU issue controller.
// Imported by alu_issue_ctrl.
package mdu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_MULT = 4'b0001;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    EXEC_S,
    CAPTURE,
    EXEC_M,
    WAIT_M,
    ILLEGAL,
    ERR
  } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue stage between ID/EX and the multi-cycle ALU: latches one op, drives
// alu_a/alu_b/alu_op, tracks alu_busy and emits one out_valid result beat.
// Ports: clk, reset_n (async low), in_* handshake from ID/EX, alu_* to/from
// the ALU, out_* single-cycle result bundle to EX/MEM.
// Optional: define MDU_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog on
// multiply ops; a stuck ALU then reports an illegal beat and parks in ERR.
module alu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        in_op,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_regwrite,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic              alu_busy,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_regwrite,
  output logic              out_illegal
);

  issue_state_t state_q, state_d;

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              rw_q, rw_d;

  logic              ov_q, ov_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [REG_W-1:0]  ord_q, ord_d;
  logic              orw_q, orw_d;
  logic              oill_q, oill_d;

  logic              done;
  logic              done_ill;
  logic [DATA_W-1:0] done_res;

`ifdef MDU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`endif

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign out_valid    = ov_q;
  assign out_result   = res_q;
  assign out_rd       = ord_q;
  assign out_regwrite = orw_q;
  assign out_illegal  = oill_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    ov_d     = 1'b0;
    res_d    = res_q;
    ord_d    = ord_q;
    orw_d    = orw_q;
    oill_d   = oill_q;
    in_ready = 1'b0;
    alu_op   = OP_NOP;
    done     = 1'b0;
    done_ill = 1'b0;
    done_res = '0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d  = in_a;
          b_d  = in_b;
          op_d = in_op;
          rd_d = in_rd;
          rw_d = in_regwrite;
          unique case (1'b1)
            (in_op == OP_ADD):  state_d = EXEC_S;
            (in_op == OP_MULT): state_d = EXEC_M;
            default:            state_d = ILLEGAL;
          endcase
        end
      end
      EXEC_S: begin
        alu_op  = op_q;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        done     = 1'b1;
        done_res = alu_result;
        state_d  = IDLE;
      end
      EXEC_M: begin
        alu_op = OP_MULT;
        if (alu_busy) state_d = WAIT_M;
`ifdef MDU_TIMEOUT_EN
        if (tmo_hit) begin
          done     = 1'b1;
          done_ill = 1'b1;
          state_d  = ERR;
        end
`endif
      end
      WAIT_M: begin
        // Drop to NOP the same cycle busy falls, or the ALU restarts.
        if (alu_busy) begin
          alu_op = OP_MULT;
`ifdef MDU_TIMEOUT_EN
          if (tmo_hit) begin
            done     = 1'b1;
            done_ill = 1'b1;
            state_d  = ERR;
          end
`endif
        end else begin
          done     = 1'b1;
          done_res = alu_result;
          state_d  = IDLE;
        end
      end
      ILLEGAL: begin
        done     = 1'b1;
        done_ill = 1'b1;
        state_d  = IDLE;
      end
`ifdef MDU_TIMEOUT_EN
      ERR: begin
        state_d = ERR;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (done) begin
      ov_d   = 1'b1;
      res_d  = done_res;
      ord_d  = rd_q;
      orw_d  = rw_q;
      oill_d = done_ill;
    end
  end

`ifdef MDU_TIMEOUT_EN
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == EXEC_M || state_q == WAIT_M)
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      ord_q   <= '0;
      orw_q   <= 1'b0;
      oill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      ord_q   <= ord_d;
      orw_q   <= orw_d;
      oill_q  <= oill_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural multi-cycle ALU.
// Define MDU_TIMEOUT_EN to also exercise the stuck-busy watchdog.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_op = 4'hF;
  logic [4:0]  in_rd = '0;
  logic        in_regwrite = 1'b0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_busy;
  logic [31:0] alu_result;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_rd(in_rd), .in_regwrite(in_regwrite),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_busy(alu_busy), .alu_result(alu_result),
    .out_valid(out_valid), .out_result(out_result),
    .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_illegal(out_illegal)
  );

  // Behavioural ALU: ADD result registered one edge after issue; MULT
  // raises busy on the issue edge and drops it on the fifth edge.
  logic        m_busy;
  logic [2:0]  m_cnt;
  logic [31:0] m_res;
  logic        stuck = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_res  <= '0;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 3'd1;
    end else if (alu_op == 4'h1) begin
      m_busy <= 1'b1;
      m_cnt  <= 3'd3;
      m_res  <= alu_a * alu_b;
    end else if (alu_op == 4'h0) begin
      m_res  <= alu_a + alu_b;
    end
  end

  assign alu_busy   = m_busy | stuck;
  assign alu_result = m_res;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_pulse = -100;
  int   mult_issued = 0;
  int   busy_rises = 0;
  logic prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: compares every out_valid beat against the scoreboard and
  // watches the ALU opcode around busy.
  always @(negedge clk) begin
    if (reset_n) begin
      if (alu_busy && !prev_busy) busy_rises++;
      if (!stuck && prev_busy && !alu_busy)
        chk("op_nop_on_busy_fall", {28'd0, alu_op}, 32'hF);
      if (!stuck && alu_busy)
        chk("op_held_while_busy", {28'd0, alu_op}, 32'h1);
      if (out_valid) begin
        last_pulse = cyc;
        if (q.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", out_result, e.res);
          chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
          chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
          if (!e.ill)
            chk("regwrite", {31'd0, out_regwrite}, {31'd0, e.rw});
          chk("latency", cyc - e.acc, e.lat);
        end
      end
    end
    prev_busy = alu_busy;
  end

  // Drive one op and hold it until accepted; push its expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [4:0] rd,
                       input logic rw, input logic [31:0] res,
                       input logic ill, input int lat,
                       output int acc);
    int n;
    exp_t e;
    in_valid    = 1'b1;
    in_a        = a;
    in_b        = b;
    in_op       = op;
    in_rd       = rd;
    in_regwrite = rw;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = -1;
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc = cyc;
      if (op == 4'h1) mult_issued++;
      e.res = res;
      e.rd  = rd;
      e.rw  = rw;
      e.ill = ill;
      e.lat = lat;
      e.acc = acc;
      q.push_back(e);
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc2;

    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_op", {28'd0, alu_op}, 32'hF);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ADD 5+7, then in_ready low for exactly two cycles
    issue(32'd5, 32'd7, 4'h0, 5'd3, 1'b1, 32'd12, 1'b0, 2, acc);
    @(negedge clk);
    chk("add_ready_c1", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("add_ready_c2", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("add_ready_c3", {31'd0, in_ready}, 32'd1);
    drain();

    // MULT 0x102*3
    issue(32'h102, 32'h3, 4'h1, 5'd9, 1'b1, 32'h306, 1'b0, 6, acc);
    drain();
    repeat (4) @(negedge clk);

    // Illegal op, then ADD 1+1 clears out_illegal
    issue(32'd4, 32'd4, 4'h7, 5'd6, 1'b1, 32'd0, 1'b1, 1, acc);
    issue(32'd1, 32'd1, 4'h0, 5'd7, 1'b1, 32'd2, 1'b0, 2, acc);
    drain();

    // ADD wraparound, regwrite low
    issue(32'hFFFF_FFFF, 32'd1, 4'h0, 5'd31, 1'b0, 32'd0, 1'b0, 2, acc);
    drain();

    // Back-to-back: ADD held while MULT runs, accepted on the pulse cycle
    issue(32'h10, 32'h10, 4'h1, 5'd1, 1'b1, 32'h100, 1'b0, 6, acc);
    issue(32'h20, 32'h22, 4'h0, 5'd2, 1'b1, 32'h42, 1'b0, 2, acc2);
    chk("b2b_accept_on_pulse", acc2, last_pulse + 1);
    drain();
    repeat (6) @(negedge clk);
    chk("busy_rises", busy_rises, mult_issued);

    // Reset mid-WAIT_M abandons the op
    issue(32'h7, 32'h9, 4'h1, 5'd4, 1'b1, 32'h3F, 1'b0, 6, acc);
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_alu_op", {28'd0, alu_op}, 32'hF);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    void'(q.pop_back());
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_pulse", q.size(), 0);

    // Post-reset sanity
    issue(32'd100, 32'd23, 4'h0, 5'd5, 1'b1, 32'd123, 1'b0, 2, acc);
    drain();

`ifdef MDU_TIMEOUT_EN
    stuck = 1'b1;
    issue(32'd2, 32'd3, 4'h1, 5'd8, 1'b1, 32'd0, 1'b1, 16, acc);
    drain();
    repeat (20) @(negedge clk);
    chk("err_in_ready", {31'd0, in_ready}, 32'd0);
    chk("err_alu_op", {28'd0, alu_op}, 32'hF);
    #1;
    reset_n = 1'b0;
    stuck = 1'b0;
    #1;
    chk("err_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
`endif

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/handshake stage between the ID/EX pipeline register and the multi-cycle ALU.
- Captures one operation, drives stable operands and opcode into the ALU, and tracks the ALU's busy signal.
- Returns one result beat to EX/MEM and back-pressures the pipeline through in_ready.
- Keeps the ALU opcode stable for exactly as long as the ALU needs it, so the ALU never restarts or sticks in busy.

Parameters:
- DATA_W, 32, operand/result width.
- REG_W, 5, destination register index width.
- TIMEOUT_CYCLES, 16, watchdog limit for a multi-cycle op (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID/EX holds a valid EX-stage operation.
- in_ready  out  1  block can accept; pipeline stalls IF/ID/ID-EX while in_ready=0.
- in_a, in_b  in  DATA_W  operands.
- in_op  in  4  ALU opcode.
- in_rd  in  REG_W  destination register.
- in_regwrite  in  1  writeback enable.
- alu_a, alu_b  out  DATA_W  operands to the ALU, registered and stable while an op is in flight.
- alu_op  out  4  opcode to the ALU.
- alu_busy  in  1  ALU busy.
- alu_result  in  DATA_W  ALU result.
- out_valid  out  1  one-cycle result pulse to EX/MEM.
- out_result  out  DATA_W  result.
- out_rd  out  REG_W  destination register.
- out_regwrite  out  1  writeback enable.
- out_illegal  out  1  the op was unsupported; out_result=0.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, in_ready=1.
  - All out_* = 0.
  - alu_a=alu_b=0, alu_op=OP_NOP (4'hF).
  - Reset mid-operation abandons the op; no out_valid pulse is produced.
- Accept: on a clock edge with in_valid & in_ready, latch in_a, in_b, in_op, in_rd, in_regwrite. in_ready=1 only in IDLE.
- States:
  - IDLE: alu_op=OP_NOP.
    - Accepted op == OP_ADD (4'b0000) -> EXEC_S.
    - Accepted op == OP_MULT (4'b0001) -> EXEC_M.
    - Any other accepted op -> ILLEGAL.
  - EXEC_S: alu_op=latched op. -> CAPTURE unconditionally.
  - CAPTURE: alu_op=OP_NOP. At the edge, register out_result<=alu_result and out_valid<=1. -> IDLE.
  - EXEC_M: alu_op=OP_MULT, issued with alu_busy=0. -> WAIT_M when alu_busy=1 is sampled; stay in EXEC_M otherwise.
  - WAIT_M:
    - While alu_busy=1, alu_op=OP_MULT.
    - When alu_busy=0, alu_op=OP_NOP combinationally in the same cycle; this is mandatory to prevent an ALU restart.
    - In that alu_busy=0 cycle, register out_result<=alu_result and out_valid<=1, then -> IDLE.
  - ILLEGAL: out_valid<=1, out_illegal<=1, out_result<=0. -> IDLE.
- Latency, counted from the accept edge:
  - ADD: out_valid high after edge +2.
  - ILLEGAL: out_valid high after edge +1.
  - MULT: out_valid high after edge +6 (ALU takes 5 edges busy->done, plus capture).
- out_valid is a single-cycle pulse. out_rd, out_regwrite and out_illegal are valid only with out_valid.
- Downstream cannot back-pressure.
- out_result etc. hold their last value until the next pulse, except out_illegal, which is cleared on the next pulse.
- A new op may be accepted in the cycle out_valid is high (the state is already IDLE).
- alu_a/alu_b update only on accept.
- The ALU's done output is not used; it is not a reliable per-op strobe.

Optional Feature:
- MDU_TIMEOUT_EN defined:
  - A cycle counter runs in EXEC_M/WAIT_M.
  - If it reaches TIMEOUT_CYCLES without alu_busy falling, emit out_valid with out_illegal=1, out_result=0, and enter state ERR.
  - In ERR: in_ready=0 and alu_op=OP_NOP permanently until reset_n.
- MDU_TIMEOUT_EN undefined: no counter, no ERR state; WAIT_M waits indefinitely.

Decomposition:
- Shared package mdu_pkg holds:
  - Opcode constants OP_ADD=4'b0000, OP_MULT=4'b0001, OP_NOP=4'b1111.
  - State enum issue_state_t (IDLE, EXEC_S, CAPTURE, EXEC_M, WAIT_M, ILLEGAL, ERR).
- No sub-module; the timeout counter is inline under the macro.

Test Plan:
- Reset: reset_n=0 mid-WAIT_M -> in_ready=1, alu_op=4'hF, out_valid=0 the same cycle; no later pulse.
- ADD: a=5, b=7, op=0, rd=3, regwrite=1 -> in_ready low for 2 cycles; out_valid one cycle, out_result=12, out_rd=3, out_regwrite=1.
- MULT: a=0x00000102, b=0x00000003 with the real ALU -> alu_op=0001 held until alu_busy falls and is 4'hF in that cycle; out_valid at accept+6; out_result=0x306; ALU never re-asserts busy afterwards.
- Illegal op=4'h7 -> out_valid at accept+1, out_illegal=1, out_result=0; next op ADD 1+1 -> out_illegal=0, out_result=2.
- Back-to-back ops: MULT then ADD held on in_valid -> ADD accepted on the MULT out_valid edge; two pulses, in order, correct values.
- MDU_TIMEOUT_EN: alu_busy stuck at 1 -> pulse with out_illegal=1 after TIMEOUT_CYCLES=16; in_ready stays 0 until reset_n.
